// File: rtl/ad9958_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ad9958_pkg
//  Description : Shared constants for the AD9958 serial write protocol:
//                register addresses, data nibble counts per address, reset
//                defaults and the responder FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ad9958_pkg;

    localparam int          NUM_CH        = 2;

    localparam logic [4:0]  C_ADDR_CSR    = 5'h00;
    localparam logic [4:0]  C_ADDR_FR1    = 5'h01;
    localparam logic [4:0]  C_ADDR_FR2    = 5'h02;
    localparam logic [4:0]  C_ADDR_CFR    = 5'h03;
    localparam logic [4:0]  C_ADDR_CFTW0  = 5'h04;
    localparam logic [4:0]  C_ADDR_CPOW0  = 5'h05;
    localparam logic [4:0]  C_ADDR_ACR    = 5'h06;

    localparam logic [7:0]  C_CSR_DEFAULT = 8'hF0;
    localparam logic [23:0] C_CFR_DEFAULT = 24'h000302;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INSTR  = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Number of data nibbles that follow the instruction byte. Unknown
    // addresses still consume a full 32-bit word so the frame stays aligned.
    function automatic logic [3:0] nibble_count(input logic [4:0] addr);
        case (addr)
            C_ADDR_CSR:   nibble_count = 4'd2;
            C_ADDR_FR1:   nibble_count = 4'd6;
            C_ADDR_FR2:   nibble_count = 4'd4;
            C_ADDR_CFR:   nibble_count = 4'd6;
            C_ADDR_CFTW0: nibble_count = 4'd8;
            C_ADDR_CPOW0: nibble_count = 4'd4;
            C_ADDR_ACR:   nibble_count = 4'd6;
            default:      nibble_count = 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9958_spi_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : ad9958_spi_sampler
//  Description : Brings the asynchronous SPI pins and control strobes into
//                the system clock domain and produces single-cycle events.
//  Ports       : clock, reset_n       - system clock, async active-low reset
//                i_sclk/i_cs_n/i_sdio - raw SPI pins
//                i_io_update          - raw io_update pin
//                i_master_reset       - raw master_reset pin
//                o_nibble_valid       - one-cycle strobe, nibble on o_nibble
//                o_io_update_rise     - one-cycle strobe on io_update rise
//                o_master_reset       - synchronized master_reset level
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9958_spi_sampler (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic [3:0] i_sdio,
    input  logic       i_io_update,
    input  logic       i_master_reset,
    output logic       o_nibble_valid,
    output logic [3:0] o_nibble,
    output logic       o_io_update_rise,
    output logic       o_master_reset
);

    // Bit layout of the synchronizer vector:
    // [3:0] sdio, [4] sclk, [5] cs_n, [6] io_update, [7] master_reset
    localparam logic [7:0] C_SYNC_RESET = 8'b0010_0000;   // cs_n idles high

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic       r_sclk_prev;
    logic       r_ioup_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= C_SYNC_RESET;
            r_sync2     <= C_SYNC_RESET;
            r_sclk_prev <= 1'b0;
            r_ioup_prev <= 1'b0;
        end else begin
            r_sync1     <= {i_master_reset, i_io_update, i_cs_n, i_sclk, i_sdio};
            r_sync2     <= r_sync1;
            r_sclk_prev <= r_sync2[4];
            r_ioup_prev <= r_sync2[6];
        end
    end

    // sdio travels through the same two stages as sclk, so the nibble seen
    // with the detected edge is the one present at the pin edge.
    assign o_nibble_valid   = r_sync2[4] & ~r_sclk_prev & ~r_sync2[5];
    assign o_nibble         = r_sync2[3:0];
    assign o_io_update_rise = r_sync2[6] & ~r_ioup_prev;
    assign o_master_reset   = r_sync2[7];

endmodule
`default_nettype wire

// File: rtl/ad9958_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ad9958_spi_responder
//  Description : Far-end model of the AD9958 quad-SPI write path. Decodes
//                instruction + data frames into a buffered register file and
//                exposes the active registers.
//  Ports       : clock, reset_n       - system clock, async active-low reset
//                sclk, cs_n, sdio     - quad SPI pins (async)
//                io_update            - buffer-to-active transfer (async)
//                master_reset         - level reset to defaults (async)
//                csr ... asf_ch1      - active register values
//                write_valid/addr     - commit pulse and its address
//                proto_error          - pulse on read / unsupported address
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9958_spi_responder
    import ad9958_pkg::*;
#(
    parameter int MIN_OVERSAMPLE = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic [3:0]  sdio,
    input  logic        io_update,
    input  logic        master_reset,
    output logic [7:0]  csr,
    output logic [23:0] fr1,
    output logic [15:0] fr2,
    output logic [23:0] cfr_ch0,
    output logic [23:0] cfr_ch1,
    output logic [31:0] ftw_ch0,
    output logic [31:0] ftw_ch1,
    output logic [15:0] pow_ch0,
    output logic [15:0] pow_ch1,
    output logic [23:0] asf_ch0,
    output logic [23:0] asf_ch1,
    output logic        write_valid,
    output logic [4:0]  write_addr,
    output logic        proto_error
);

    generate
        if (MIN_OVERSAMPLE < 4) begin : g_ratio_check
            $error("MIN_OVERSAMPLE below 4 is not a supported operating point");
        end
    endgenerate

    logic       w_nib_valid;
    logic [3:0] w_nibble;
    logic       w_io_rise;
    logic       w_mreset;

    ad9958_spi_sampler u_sampler (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_sclk           (sclk),
        .i_cs_n           (cs_n),
        .i_sdio           (sdio),
        .i_io_update      (io_update),
        .i_master_reset   (master_reset),
        .o_nibble_valid   (w_nib_valid),
        .o_nibble         (w_nibble),
        .o_io_update_rise (w_io_rise),
        .o_master_reset   (w_mreset)
    );

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_shift;
    logic [3:0]  r_nib_cnt;
    logic [3:0]  r_need;
    logic [4:0]  r_addr;
    logic        r_drop;

    logic [7:0]  r_csr;
    logic [23:0] r_fr1_buf, r_fr1_act;
    logic [15:0] r_fr2_buf, r_fr2_act;
    logic [23:0] r_cfr_buf [NUM_CH];
    logic [23:0] r_cfr_act [NUM_CH];
    logic [31:0] r_ftw_buf [NUM_CH];
    logic [31:0] r_ftw_act [NUM_CH];
    logic [15:0] r_pow_buf [NUM_CH];
    logic [15:0] r_pow_act [NUM_CH];
    logic [23:0] r_asf_buf [NUM_CH];
    logic [23:0] r_asf_act [NUM_CH];
    logic        r_write_valid;
    logic [4:0]  r_write_addr;
    logic        r_proto_error;

    // The instruction's high nibble already sits in r_shift[3:0] when the
    // low nibble arrives; bits 6:5 of the instruction are don't-care.
    logic       w_instr_read;
    logic [4:0] w_instr_addr;
    logic       w_instr_bad;
    assign w_instr_read = r_shift[3];
    assign w_instr_addr = {r_shift[0], w_nibble};
    assign w_instr_bad  = w_instr_read || (w_instr_addr > C_ADDR_ACR);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (w_mreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_nib_valid) w_state_next = ST_INSTR;
            ST_INSTR:  if (w_nib_valid) w_state_next = ST_DATA;
            ST_DATA:   if (w_nib_valid && (r_nib_cnt == r_need - 4'd1))
                           w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------ datapath and register file
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift       <= '0;
            r_nib_cnt     <= '0;
            r_need        <= '0;
            r_addr        <= '0;
            r_drop        <= 1'b0;
            r_csr         <= C_CSR_DEFAULT;
            r_fr1_buf     <= '0;
            r_fr1_act     <= '0;
            r_fr2_buf     <= '0;
            r_fr2_act     <= '0;
            r_write_valid <= 1'b0;
            r_write_addr  <= '0;
            r_proto_error <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cfr_buf[ch] <= C_CFR_DEFAULT;
                r_cfr_act[ch] <= C_CFR_DEFAULT;
                r_ftw_buf[ch] <= '0;
                r_ftw_act[ch] <= '0;
                r_pow_buf[ch] <= '0;
                r_pow_act[ch] <= '0;
                r_asf_buf[ch] <= '0;
                r_asf_act[ch] <= '0;
            end
        end else if (w_mreset) begin
            r_shift       <= '0;
            r_nib_cnt     <= '0;
            r_need        <= '0;
            r_addr        <= '0;
            r_drop        <= 1'b0;
            r_csr         <= C_CSR_DEFAULT;
            r_fr1_buf     <= '0;
            r_fr1_act     <= '0;
            r_fr2_buf     <= '0;
            r_fr2_act     <= '0;
            r_write_valid <= 1'b0;
            r_write_addr  <= '0;
            r_proto_error <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cfr_buf[ch] <= C_CFR_DEFAULT;
                r_cfr_act[ch] <= C_CFR_DEFAULT;
                r_ftw_buf[ch] <= '0;
                r_ftw_act[ch] <= '0;
                r_pow_buf[ch] <= '0;
                r_pow_act[ch] <= '0;
                r_asf_buf[ch] <= '0;
                r_asf_act[ch] <= '0;
            end
        end else begin
            r_write_valid <= 1'b0;
            r_proto_error <= 1'b0;

            if (w_nib_valid && (r_state != ST_COMMIT)) begin
                r_shift <= {r_shift[27:0], w_nibble};
            end

            if (w_nib_valid && (r_state == ST_INSTR)) begin
                r_addr        <= w_instr_addr;
                r_drop        <= w_instr_bad;
                r_need        <= nibble_count(w_instr_addr);
                r_nib_cnt     <= '0;
                r_proto_error <= w_instr_bad;
            end else if (w_nib_valid && (r_state == ST_DATA)) begin
                r_nib_cnt <= r_nib_cnt + 4'd1;
            end

            // Ordered before the commit so that a same-cycle io_update
            // transfers the buffer contents from before this commit.
            if (w_io_rise) begin
                r_fr1_act <= r_fr1_buf;
                r_fr2_act <= r_fr2_buf;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    r_cfr_act[ch] <= r_cfr_buf[ch];
                    r_ftw_act[ch] <= r_ftw_buf[ch];
                    r_pow_act[ch] <= r_pow_buf[ch];
                    r_asf_act[ch] <= r_asf_buf[ch];
                end
            end

            // The frame's data occupies the low bits of r_shift, MSB-first.
            if ((r_state == ST_COMMIT) && !r_drop) begin
                r_write_valid <= 1'b1;
                r_write_addr  <= r_addr;
                case (r_addr)
                    C_ADDR_CSR: r_csr     <= r_shift[7:0];
                    C_ADDR_FR1: r_fr1_buf <= r_shift[23:0];
                    C_ADDR_FR2: r_fr2_buf <= r_shift[15:0];
                    default: begin
                        // csr[6] enables ch0, csr[7] enables ch1
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            if (r_csr[6+ch]) begin
                                case (r_addr)
                                    C_ADDR_CFR:   r_cfr_buf[ch] <= r_shift[23:0];
                                    C_ADDR_CFTW0: r_ftw_buf[ch] <= r_shift;
                                    C_ADDR_CPOW0: r_pow_buf[ch] <= r_shift[15:0];
                                    default:      r_asf_buf[ch] <= r_shift[23:0];
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign csr         = r_csr;
    assign fr1         = r_fr1_act;
    assign fr2         = r_fr2_act;
    assign cfr_ch0     = r_cfr_act[0];
    assign cfr_ch1     = r_cfr_act[1];
    assign ftw_ch0     = r_ftw_act[0];
    assign ftw_ch1     = r_ftw_act[1];
    assign pow_ch0     = r_pow_act[0];
    assign pow_ch1     = r_pow_act[1];
    assign asf_ch0     = r_asf_act[0];
    assign asf_ch1     = r_asf_act[1];
    assign write_valid = r_write_valid;
    assign write_addr  = r_write_addr;
    assign proto_error = r_proto_error;

endmodule
`default_nettype wire
